// File: rtl/pool_relu_stage_if.sv
`default_nettype none
// ============================================================================
// Module   : pool_relu_stage_if
// Brief    : Row-stream handshake bundle for pool_relu_stage (in and out side).
// Revision : 1.0
// ============================================================================
interface pool_relu_stage_if #(
    parameter int IMG_ROW = 54,
    parameter int DATA_W  = 16
);
    logic [1:0]                cfg_mode;
    logic                      in_valid;
    logic                      in_ready;
    logic                      in_last;
    logic [IMG_ROW*DATA_W-1:0] in_value;
    logic                      out_valid;
    logic                      out_ready;
    logic                      out_last;
    logic [IMG_ROW*DATA_W-1:0] out_value;

    modport master (
        output cfg_mode, in_valid, in_last, in_value, out_ready,
        input  in_ready, out_valid, out_last, out_value
    );

    modport slave (
        input  cfg_mode, in_valid, in_last, in_value, out_ready,
        output in_ready, out_valid, out_last, out_value
    );
endinterface
`default_nettype wire

// File: rtl/pool_relu_stage.sv
`default_nettype none
// ============================================================================
// Module   : pool_relu_stage
// Brief    : Row-streaming 2x2 / 2x1 max-pool plus leaky-ReLU with a
//            registered valid/ready output.
// Revision : 1.0
// ============================================================================
module pool_relu_stage #(
    parameter int IMG_ROW     = 54,
    parameter int DATA_W      = 16,
    parameter int ALPHA_SHIFT = 3
) (
    input  wire logic        clk,
    input  wire logic        reset,
    pool_relu_stage_if.slave bus
);
    localparam int c_half = IMG_ROW / 2;

    typedef enum logic [0:0] {
        EVEN = 1'b0,
        ODD  = 1'b1
    } phase_t;

    phase_t                    r_phase;
    phase_t                    w_phase_nxt;
    logic [1:0]                r_mode;
    logic [1:0]                w_mode_nxt;
    logic [1:0]                w_mode;
    logic signed [DATA_W-1:0]  w_lane [IMG_ROW];
    logic signed [DATA_W-1:0]  w_h    [c_half];
    logic signed [DATA_W-1:0]  r_buf  [c_half];
    logic                      w_accept;
    logic                      w_produce;
    logic                      w_store;
    logic                      w_last_nxt;
    logic [IMG_ROW*DATA_W-1:0] w_value_nxt;
    logic                      r_out_valid;
    logic                      r_out_last;
    logic [IMG_ROW*DATA_W-1:0] r_out_value;

    function automatic logic signed [DATA_W-1:0] leaky(input logic signed [DATA_W-1:0] x);
        return x[DATA_W-1] ? (x >>> ALPHA_SHIFT) : x;
    endfunction

    function automatic logic signed [DATA_W-1:0] smax(input logic signed [DATA_W-1:0] a,
                                                      input logic signed [DATA_W-1:0] b);
        return (a > b) ? a : b;
    endfunction

    for (genvar k = 0; k < IMG_ROW; k++) begin : g_lane
        assign w_lane[k] = $signed(bus.in_value[k*DATA_W +: DATA_W]);
    end

    for (genvar j = 0; j < c_half; j++) begin : g_hmax
        assign w_h[j] = smax(w_lane[2*j], w_lane[2*j+1]);
    end

    assign bus.in_ready  = !r_out_valid || bus.out_ready;
    assign w_accept      = bus.in_valid && bus.in_ready;
    // The pair's mode is frozen in ODD so a mid-pair cfg change waits for the pair.
    assign w_mode        = (r_phase == EVEN) ? bus.cfg_mode : r_mode;

    always_comb begin
        w_phase_nxt = r_phase;
        w_mode_nxt  = r_mode;
        w_produce   = 1'b0;
        w_store     = 1'b0;
        w_last_nxt  = bus.in_last;
        w_value_nxt = '0;
        if (w_accept) begin
            if (r_phase == EVEN) begin
                w_mode_nxt = bus.cfg_mode;
            end
            if (!w_mode[1]) begin
                w_produce = 1'b1;
                if (w_mode[0]) begin
                    for (int j = 0; j < c_half; j++) begin
                        w_value_nxt[j*DATA_W +: DATA_W] = leaky(w_h[j]);
                    end
                end else begin
                    for (int k = 0; k < IMG_ROW; k++) begin
                        w_value_nxt[k*DATA_W +: DATA_W] = leaky(w_lane[k]);
                    end
                end
            end else if (r_phase == ODD) begin
                w_produce   = 1'b1;
                w_phase_nxt = EVEN;
                for (int j = 0; j < c_half; j++) begin
                    w_value_nxt[j*DATA_W +: DATA_W] = leaky(smax(r_buf[j], w_h[j]));
                end
            end else if (bus.in_last) begin
                // Odd row count: the unpaired last row is pooled horizontally only.
                w_produce = 1'b1;
                for (int j = 0; j < c_half; j++) begin
                    w_value_nxt[j*DATA_W +: DATA_W] = leaky(w_h[j]);
                end
            end else begin
                w_store     = 1'b1;
                w_phase_nxt = ODD;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_phase <= EVEN;
            r_mode  <= 2'b00;
        end else begin
            r_phase <= w_phase_nxt;
            r_mode  <= w_mode_nxt;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_out_value <= '0;
            for (int j = 0; j < c_half; j++) begin
                r_buf[j] <= '0;
            end
        end else begin
            if (w_store) begin
                for (int j = 0; j < c_half; j++) begin
                    r_buf[j] <= w_h[j];
                end
            end
            if (w_produce) begin
                r_out_valid <= 1'b1;
                r_out_last  <= w_last_nxt;
                r_out_value <= w_value_nxt;
            end else if (bus.out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign bus.out_valid = r_out_valid;
    assign bus.out_last  = r_out_last;
    assign bus.out_value = r_out_value;
endmodule
`default_nettype wire

// File: tb/tb_pool_relu_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_pool_relu_stage
// Brief    : Scoreboard bench for pool_relu_stage with a behavioural row model.
// Revision : 1.0
// ============================================================================
module tb_pool_relu_stage;
    localparam int IMG_ROW     = 4;
    localparam int DATA_W      = 16;
    localparam int ALPHA_SHIFT = 3;
    localparam int HALF        = IMG_ROW / 2;
    localparam int W           = IMG_ROW * DATA_W;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    pool_relu_stage_if #(.IMG_ROW(IMG_ROW), .DATA_W(DATA_W)) bus ();

    pool_relu_stage #(
        .IMG_ROW    (IMG_ROW),
        .DATA_W     (DATA_W),
        .ALPHA_SHIFT(ALPHA_SHIFT)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.slave)
    );

    typedef struct packed {
        logic         last;
        logic [W-1:0] value;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    bit   model_pending = 0;
    int   pend_h[HALF];
    bit   chk_valid = 0;
    bit   hold_low = 0;
    int   ready_pct = 100;

    function automatic void check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endfunction

    function automatic int relu_ref(input int x);
        if (x >= 0) return x;
        return -((-x + (1 << ALPHA_SHIFT) - 1) / (1 << ALPHA_SHIFT));
    endfunction

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    function automatic logic [W-1:0] pack_row(input int v[IMG_ROW]);
        logic [W-1:0] r;
        for (int k = 0; k < IMG_ROW; k++) r[k*DATA_W +: DATA_W] = v[k][DATA_W-1:0];
        return r;
    endfunction

    // Reference: h = pairwise max; 2x2 pairs rows, an unpaired last row pools horizontally.
    task automatic model_accept(input int row[IMG_ROW], input bit last, input logic [1:0] cfg,
                                output bit emit);
        int h[HALF];
        int o[IMG_ROW];
        int mode;
        emit = 0;
        for (int j = 0; j < HALF; j++) h[j] = imax(row[2*j], row[2*j+1]);
        for (int k = 0; k < IMG_ROW; k++) o[k] = 0;
        if (model_pending) begin
            for (int j = 0; j < HALF; j++) o[j] = relu_ref(imax(pend_h[j], h[j]));
            model_pending = 0;
            emit = 1;
        end else begin
            mode = (cfg == 2'b11) ? 2 : int'(cfg);
            if (mode == 0) begin
                for (int k = 0; k < IMG_ROW; k++) o[k] = relu_ref(row[k]);
                emit = 1;
            end else if (mode == 1 || last) begin
                for (int j = 0; j < HALF; j++) o[j] = relu_ref(h[j]);
                emit = 1;
            end else begin
                pend_h = h;
                model_pending = 1;
            end
        end
        if (emit) exp_q.push_back('{last: last, value: pack_row(o)});
    endtask

    function automatic bit pick_ready();
        if (hold_low) return 1'b0;
        return ($urandom_range(0, 99) < ready_pct);
    endfunction

    function automatic int rand_lane();
        case ($urandom_range(0, 7))
            0: return -32768;
            1: return 32767;
            2: return 0;
            3: return -1;
            default: return int'($urandom_range(0, 65535)) - 32768;
        endcase
    endfunction

    task automatic send_row(input int row[IMG_ROW], input bit last, input logic [1:0] cfg);
        bit done = 0;
        bit produced = 0;
        int tries = 0;
        while (!done) begin
            @(negedge clk);
            bus.in_valid  = 1'b1;
            bus.in_last   = last;
            bus.cfg_mode  = cfg;
            bus.in_value  = pack_row(row);
            bus.out_ready = pick_ready();
            #1;
            if (bus.in_ready) begin
                model_accept(row, last, cfg, produced);
                done = 1;
            end
            @(posedge clk);
            if (done && produced) chk_valid = 1;
            tries++;
            if (!done && tries > 200) begin
                n_cmp++;
                n_err++;
                $display("FAIL accept_timeout: in_ready stuck 0 for %0d cycles", tries);
                done = 1;
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            bus.in_valid  = 1'b0;
            bus.in_value  = {$urandom, $urandom};
            bus.out_ready = pick_ready();
            @(posedge clk);
        end
    endtask

    task automatic expect_out(input int v[IMG_ROW], input bit last, input string name);
        @(negedge clk);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        #2;
        check({name, "_valid"}, W'(bus.out_valid), W'(1));
        check({name, "_value"}, bus.out_value, pack_row(v));
        check({name, "_last"}, W'(bus.out_last), W'(last));
        @(posedge clk);
    endtask

    task automatic expect_idle(input string name);
        @(negedge clk);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        #2;
        check(name, W'(bus.out_valid), W'(0));
        @(posedge clk);
    endtask

    task automatic do_reset(input int cycles);
        @(negedge clk);
        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        model_pending = 0;
        exp_q.delete();
        chk_valid     = 0;
        repeat (cycles) @(negedge clk);
        reset = 1'b0;
        #1;
        check("rst_out_valid", W'(bus.out_valid), W'(0));
        check("rst_out_last", W'(bus.out_last), W'(0));
        check("rst_out_value", bus.out_value, W'(0));
        check("rst_in_ready", W'(bus.in_ready), W'(1));
    endtask

    // Monitor: handshake rule, latency, backpressure stability and scoreboard pops.
    initial begin
        bit           prev_stall = 0;
        logic [W-1:0] prev_v = '0;
        logic         prev_l = 1'b0;
        exp_t         e;
        forever begin
            @(negedge clk);
            #3;
            if (reset) begin
                prev_stall = 0;
                chk_valid  = 0;
            end else begin
                check("in_ready_rule", W'(bus.in_ready), W'(!bus.out_valid || bus.out_ready));
                if (chk_valid) begin
                    check("latency_valid", W'(bus.out_valid), W'(1));
                    chk_valid = 0;
                end
                if (prev_stall) begin
                    check("stall_valid", W'(bus.out_valid), W'(1));
                    check("stall_value", bus.out_value, prev_v);
                    check("stall_last", W'(bus.out_last), W'(prev_l));
                end
                if (bus.out_valid && bus.out_ready) begin
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL unexpected_out: value %h with empty scoreboard", bus.out_value);
                    end else begin
                        e = exp_q.pop_front();
                        check("sb_value", bus.out_value, e.value);
                        check("sb_last", W'(bus.out_last), W'(e.last));
                    end
                end
                prev_stall = bus.out_valid && !bus.out_ready;
                prev_v     = bus.out_value;
                prev_l     = bus.out_last;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int ra[IMG_ROW];
        int rb[IMG_ROW];
        int ev[IMG_ROW];
        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_last   = 1'b0;
        bus.cfg_mode  = 2'b00;
        bus.in_value  = '0;
        bus.out_ready = 1'b0;
        do_reset(3);

        ready_pct = 100;
        ra = '{5, -8, 0, -1};
        send_row(ra, 1'b0, 2'b00);
        ev = '{5, -1, 0, -1};
        expect_out(ev, 1'b0, "m00");

        ra = '{3, 7, -16, -24};
        send_row(ra, 1'b0, 2'b01);
        ev = '{7, -2, 0, 0};
        expect_out(ev, 1'b0, "m01");

        ra = '{1, 2, -40, -8};
        rb = '{4, -3, -16, -32};
        send_row(ra, 1'b0, 2'b10);
        expect_idle("m10_no_out_after_a");
        send_row(rb, 1'b1, 2'b10);
        ev = '{4, -1, 0, 0};
        expect_out(ev, 1'b1, "m10_pair");

        // Three-row frame in mode 11 (aliases 2x2) with a mid-pair cfg change.
        for (int r = 0; r < 3; r++) begin
            for (int k = 0; k < IMG_ROW; k++) ra[k] = rand_lane();
            send_row(ra, r == 2, (r == 1) ? 2'b00 : 2'b11);
        end
        idle(2);

        // Backpressure: stall with data held, then drain and refill in the same cycle.
        hold_low = 1;
        for (int k = 0; k < IMG_ROW; k++) ra[k] = rand_lane();
        send_row(ra, 1'b0, 2'b00);
        repeat (5) begin
            @(negedge clk);
            bus.in_valid  = 1'b1;
            bus.out_ready = 1'b0;
            #2;
            check("bp_in_ready", W'(bus.in_ready), W'(0));
            @(posedge clk);
        end
        hold_low = 0;
        for (int k = 0; k < IMG_ROW; k++) ra[k] = rand_lane();
        send_row(ra, 1'b1, 2'b01);
        idle(2);

        // Reset mid-pair discards the buffered row.
        for (int k = 0; k < IMG_ROW; k++) ra[k] = rand_lane();
        send_row(ra, 1'b0, 2'b10);
        do_reset(1);
        for (int k = 0; k < IMG_ROW; k++) ra[k] = rand_lane();
        send_row(ra, 1'b0, 2'b10);
        expect_idle("post_rst_no_out");
        for (int k = 0; k < IMG_ROW; k++) ra[k] = rand_lane();
        send_row(ra, 1'b0, 2'b01);
        idle(2);

        for (int n = 0; n < 400; n++) begin
            if (n % 50 == 0) ready_pct = (n % 150 == 0) ? 100 : ((n % 100 == 0) ? 30 : 70);
            for (int k = 0; k < IMG_ROW; k++) ra[k] = rand_lane();
            send_row(ra, $urandom_range(0, 3) == 0, 2'($urandom_range(0, 3)));
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
        end

        ready_pct = 100;
        idle(6);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d expected rows never appeared, expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/pool_relu_stage.md
# pool_relu_stage

Parametrised row-streaming 2×2 / 2×1 max-pooling plus leaky-ReLU stage that sits between the convolution PE array and the feature-map writeback. It accepts one full image row of signed conv results per handshake and buffers the first row of each vertical pair. It emits pooled, activated rows through a registered valid/ready output. It supports bypass, horizontal-only and full 2×2 modes, with odd-row-count frames.

## Interface
- IMG_ROW, 54, lanes per row; even, ≥2
- DATA_W, 16, signed lane width
- ALPHA_SHIFT, 3, negative-slope shift (slope = 2^-ALPHA_SHIFT)

- clk  in  1  system clock; all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- cfg_mode  in  2  00 bypass (ReLU only), 01 pool 2×1 horizontal, 10 pool 2×2, 11 treated as 10
- in_valid  in  1  in_value/in_last valid
- in_ready  out  1  stage can accept a row
- in_last  in  1  row is the last of the frame
- in_value  in  IMG_ROW*DATA_W  lane k at [(k+1)*DATA_W-1 : k*DATA_W], two's complement
- out_valid  out  1  out_value/out_last valid
- out_ready  in  1  downstream accepts
- out_last  out  1  output row is the last of the frame
- out_value  out  IMG_ROW*DATA_W  same lane layout; pooled modes use lanes 0..IMG_ROW/2-1, upper lanes driven 0

## Operation
- Row accepted when in_valid && in_ready. in_ready = !out_valid || out_ready, in every mode and phase.
- Horizontal max per accepted row: h[j] = smax(lane 2j, lane 2j+1), j = 0..IMG_ROW/2-1, signed compare.
- Phase FSM has two states.
  - EVEN: no row pending.
  - ODD: row buffer holds h[] of the first row of a 2×2 pair.
- Mode latch: cfg_mode is sampled on every accepted row in EVEN and held in mode_q. It is ignored in ODD, so a mode change mid-pair takes effect after the pair completes.
- Mode 00: every accepted row → out lane k = relu(lane k). Phase stays EVEN.
- Mode 01: every accepted row → out lane j = relu(h[j]). Phase stays EVEN.
- Mode 10, accepted row in EVEN:
  - in_last=0: store h[] in row buffer, go ODD, no output.
  - in_last=1 (odd row count): emit relu(h[j]) with out_last=1, stay EVEN.
- Mode 10, accepted row in ODD: emit relu(smax(buf[j], h[j])), out_last = in_last, go EVEN.
- Leaky ReLU: relu(x) = x when x ≥ 0. Otherwise relu(x) = x >>> ALPHA_SHIFT (arithmetic shift, floor rounding, e.g. −1 → −1, −9 → −2 with shift 3). Result width DATA_W; no saturation required.
- Output register: loaded on a producing accept. out_valid clears when out_ready && !(new producing accept). Simultaneous drain and refill keeps out_valid=1 with the new data.
- in_last accepted in ODD closes the frame. The next accepted row starts EVEN and resamples cfg_mode.

## Timing
- Reset values: out_valid=0, out_last=0, out_value=0, phase=EVEN, mode_q=00, row buffer=0; in_ready=1 after reset.
- Latency: a producing accept at edge N gives out_valid=1 with its data after edge N (visible in cycle N+1).
- Throughput: one row per cycle when out_ready is held high. A non-producing accept (first row of a pair) is never stalled beyond the in_ready rule.
- Backpressure: out_value/out_last are held stable while out_valid && !out_ready.
- Reset mid-pair discards the buffered row. Reset while out_valid is high discards the pending output.
- in_valid with in_ready=0 is not accepted, and phase does not change.

## Test plan
- Mode 00, IMG_ROW=4, row {lane0..3} = {5, −8, 0, −1} → out {5, −1, 0, −1}, out_valid one cycle later.
- Mode 01, row {3, 7, −16, −24} → out lanes0..1 = {7, −2}, lanes2..3 = 0.
- Mode 10, row A = {1, 2, −40, −8} then row B (in_last=1) = {4, −3, −16, −32}:
  - no output after A;
  - after B, out = {4, −1, 0, 0}, out_last=1.
- Mode 10, three rows with the third marked in_last:
  - first output is pair-pooled, out_last=0;
  - second output is horizontal-only of row 3, out_last=1.
- Backpressure: hold out_ready=0 with out_valid=1 for 5 cycles → in_ready=0 and out_value stable. Raise out_ready while a producing row is offered → out_valid stays 1, new data next cycle.
- Assert reset for one cycle after row A of a mode-10 pair → outputs zero. The next accepted row is treated as EVEN (no output until its partner arrives).
